// File: rtl/deser400_pkg.sv
// deser400_pkg: shared types and sizes for the deser400 phase calibrator
package deser400_pkg;
  localparam int NUM_CH = 4;
  localparam int NUM_PH = 8;
  localparam int SCORE_W = 8;
  localparam int WIN_W = 10;
  typedef enum logic [2:0] {S_IDLE, S_SET, S_SETTLE, S_SAMPLE, S_EVAL, S_APPLY, S_DONE} state_e;
endpackage

// File: rtl/deser400_phcal_score.sv
// deser400_phcal_score: per-channel xorsum store with circular 3-tap window minimum search
module deser400_phcal_score
  import deser400_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [2:0]         waddr,
  input  logic [SCORE_W-1:0] wdata,
  input  logic               ev_en,
  input  logic               ev_first,
  input  logic [2:0]         ev_idx,
  output logic [2:0]         best,
  output logic               anydata
);
  logic [SCORE_W-1:0] mem_q [NUM_PH];
  logic [WIN_W-1:0]   min_q, win;
  logic [2:0]         best_q, prv, nxt;
  logic               any_q;
  assign prv = ev_idx - 3'd1;
  assign nxt = ev_idx + 3'd1;
  assign win = WIN_W'(mem_q[prv]) + WIN_W'(mem_q[ev_idx]) + WIN_W'(mem_q[nxt]);
  assign best = best_q;
  assign anydata = any_q;
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end
  // strict less-than keeps the lowest index on ties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q  <= '0;
      best_q <= '0;
      any_q  <= 1'b0;
    end else if (ev_en) begin
      if (ev_first || win < min_q) begin
        min_q  <= win;
        best_q <= ev_idx;
      end
      any_q <= (any_q & ~ev_first) | (|mem_q[ev_idx]);
    end
  end
endmodule

// File: rtl/deser400_phcal.sv
// deser400_phcal: sweeps phases 0..7 on four channels, picks the quietest window, writes it back
module deser400_phcal
  import deser400_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1024,
  parameter int SETTLE_W = 11
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [3:0]  ch_mask,
  input  logic [7:0]  xorsum_I,
  input  logic [7:0]  xorsum_II,
  input  logic [7:0]  xorsum_III,
  input  logic [7:0]  xorsum_IV,
  output logic        phwrite_I,
  output logic        phwrite_II,
  output logic        phwrite_III,
  output logic        phwrite_IV,
  output logic [2:0]  phdata,
  output logic        phenable_I,
  output logic        phenable_II,
  output logic        phenable_III,
  output logic        phenable_IV,
  output logic        busy,
  output logic        done,
  output logic [3:0]  nodata,
  output logic [11:0] best_phase
);
  state_e              state_q;
  logic [2:0]          idx_q;
  logic [SETTLE_W-1:0] cnt_q;
  logic [3:0]          mask_q, nodata_q, anyd, phwrite, phenable;
  logic [11:0]         best_q;
  logic [2:0]          best [NUM_CH];
  logic [7:0]          xs [NUM_CH];
  logic [1:0]          slot;
  logic                app_wr;
  assign xs[0] = xorsum_I;
  assign xs[1] = xorsum_II;
  assign xs[2] = xorsum_III;
  assign xs[3] = xorsum_IV;
  // idx_q is the sweep phase, then the eval index, then the apply slot
  assign slot = idx_q[1:0];
  assign app_wr = state_q == S_APPLY && mask_q[slot] && anyd[slot];
  assign phenable = (state_q inside {S_SET, S_SETTLE, S_SAMPLE}) ? mask_q : 4'b0000;
  assign phwrite = state_q == S_SET ? mask_q : (app_wr ? 4'b0001 << slot : 4'b0000);
  assign phdata = state_q == S_SET ? idx_q : (app_wr ? best[slot] : 3'd0);
  assign {phwrite_IV, phwrite_III, phwrite_II, phwrite_I} = phwrite;
  assign {phenable_IV, phenable_III, phenable_II, phenable_I} = phenable;
  assign busy = state_q != S_IDLE;
  assign done = state_q == S_DONE;
  assign nodata = nodata_q;
  assign best_phase = best_q;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    deser400_phcal_score u_score (
      .clk      (clk),
      .rst_n    (reset_n),
      .we       (state_q == S_SAMPLE && mask_q[i]),
      .waddr    (idx_q),
      .wdata    (xs[i]),
      .ev_en    (state_q == S_EVAL),
      .ev_first (idx_q == 3'd0),
      .ev_idx   (idx_q),
      .best     (best[i]),
      .anydata  (anyd[i])
    );
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
      nodata_q <= '0;
      best_q   <= '0;
    end else if (abort) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          mask_q <= ch_mask;
          idx_q  <= '0;
          if (ch_mask != 4'd0) begin
            nodata_q <= '0;
            state_q  <= S_SET;
          end else state_q <= S_DONE;
        end
        S_SET: begin
          cnt_q   <= '0;
          state_q <= S_SETTLE;
        end
        S_SETTLE: if (cnt_q == SETTLE_W'(SETTLE_CYCLES - 1)) state_q <= S_SAMPLE;
                  else cnt_q <= cnt_q + 1'b1;
        S_SAMPLE: begin
          idx_q   <= idx_q + 3'd1;
          state_q <= idx_q == 3'd7 ? S_EVAL : S_SET;
        end
        S_EVAL: begin
          idx_q <= idx_q + 3'd1;
          if (idx_q == 3'd7) state_q <= S_APPLY;
        end
        S_APPLY: begin
          if (idx_q == 3'd0) nodata_q <= mask_q & ~anyd;
          if (app_wr) best_q[3*slot +: 3] <= best[slot];
          idx_q <= idx_q + 3'd1;
          if (idx_q == 3'd3) state_q <= S_DONE;
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_deser400_phcal.sv
// tb_deser400_phcal: randomized sweeps against a window-minimum reference model
module tb_deser400_phcal;
  localparam int SC = 4;
  logic clk = 0, reset_n = 0, start = 0, abort = 0;
  logic [3:0] ch_mask = 0;
  logic [7:0] xorsum_I, xorsum_II, xorsum_III, xorsum_IV;
  logic phwrite_I, phwrite_II, phwrite_III, phwrite_IV;
  logic phenable_I, phenable_II, phenable_III, phenable_IV;
  logic [2:0] phdata;
  logic busy, done;
  logic [3:0] nodata, pw, pe;
  logic [11:0] best_phase;
  logic [7:0] prof [4][8];
  logic [2:0] ph_q [4] = '{default: 0};
  logic [11:0] bp_m = 0;
  logic [3:0] nd_m = 0;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  deser400_phcal #(.SETTLE_CYCLES(SC), .SETTLE_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .ch_mask(ch_mask),
    .xorsum_I(xorsum_I), .xorsum_II(xorsum_II), .xorsum_III(xorsum_III), .xorsum_IV(xorsum_IV),
    .phwrite_I(phwrite_I), .phwrite_II(phwrite_II), .phwrite_III(phwrite_III), .phwrite_IV(phwrite_IV),
    .phdata(phdata),
    .phenable_I(phenable_I), .phenable_II(phenable_II), .phenable_III(phenable_III), .phenable_IV(phenable_IV),
    .busy(busy), .done(done), .nodata(nodata), .best_phase(best_phase)
  );

  assign pw = {phwrite_IV, phwrite_III, phwrite_II, phwrite_I};
  assign pe = {phenable_IV, phenable_III, phenable_II, phenable_I};
  // phase detector model: xorsum follows the last phase written to that channel
  assign xorsum_I   = prof[0][ph_q[0]];
  assign xorsum_II  = prof[1][ph_q[1]];
  assign xorsum_III = prof[2][ph_q[2]];
  assign xorsum_IV  = prof[3][ph_q[3]];
  always @(posedge clk)
    for (int i = 0; i < 4; i++) if (pw[i]) ph_q[i] <= phdata;

  task check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] best_of(int c);
    int mn = 0, w;
    logic [2:0] b = 0;
    logic a = 0;
    for (int e = 0; e < 8; e++) begin
      w = prof[c][(e + 7) % 8] + prof[c][e] + prof[c][(e + 1) % 8];
      if (e == 0 || w < mn) begin
        mn = w;
        b = e[2:0];
      end
      a |= prof[c][e] != 0;
    end
    return {a, b};
  endfunction

  task run(input logic [3:0] m, input bit mid_start, input int rst_at);
    int lat, nsw, nap, nap_x;
    logic [23:0] sw_obs, sw_exp;
    logic [15:0] ap_obs, ap_exp;
    logic [3:0] r, anym;
    bit pen;
    lat = 0; nsw = 0; nap = 0; nap_x = 0; sw_obs = 0; sw_exp = 0; ap_obs = 0; ap_exp = 0; anym = 0; pen = 0;
    @(negedge clk);
    ch_mask = m;
    start = 1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) start = 0;
      if (mid_start && n == 10) begin start = 1; ch_mask = ~m; end
      if (mid_start && n == 11) begin start = 0; ch_mask = m; end
      if (pe != 0) pen = 1;
      if (pw != 0 && pe != 0) begin
        if (nsw < 8) sw_obs[3*nsw +: 3] = phdata;
        nsw++;
      end else if (pw != 0) begin
        for (int c = 0; c < 4; c++) if (pw[c]) begin
          ap_obs[4*c +: 4] = {1'b1, phdata};
          nap++;
        end
      end
      if (rst_at == n) begin
        #2 reset_n = 0;
        #1 check("rst_outputs", {busy, done, nodata, best_phase, pw, pe, phdata}, 0);
        @(negedge clk) reset_n = 1;
        bp_m = 0;
        nd_m = 0;
        return;
      end
      if (done) begin
        lat = n;
        break;
      end
    end
    for (int i = 0; i < 8; i++) if (m != 0) sw_exp[3*i +: 3] = i[2:0];
    for (int c = 0; c < 4; c++) begin
      r = best_of(c);
      anym[c] = r[3];
      if (m[c] && r[3]) begin
        ap_exp[4*c +: 4] = {1'b1, r[2:0]};
        bp_m[3*c +: 3] = r[2:0];
        nap_x++;
      end
    end
    if (m != 0) nd_m = m & ~anym;
    check("latency", lat, m != 0 ? 8 * (SC + 2) + 13 : 1);
    check("sweep_count", nsw, m != 0 ? 8 : 0);
    check("sweep_seq", sw_obs, sw_exp);
    check("apply_count", nap, nap_x);
    check("apply_val", ap_obs, ap_exp);
    check("best_phase", best_phase, bp_m);
    check("nodata", nodata, nd_m);
    check("phenable_seen", pen, m != 0);
  endtask

  initial begin
    bit got, bad;
    logic [7:0] a_prof [8] = '{90, 80, 10, 0, 5, 70, 90, 95};
    logic [7:0] t_prof [8] = '{0, 50, 50, 50, 50, 50, 50, 0};
    for (int c = 0; c < 4; c++) for (int p = 0; p < 8; p++) prof[c][p] = 0;
    repeat (3) @(negedge clk);
    check("rst_busy_low", busy, 0);
    reset_n = 1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_best", best_phase, 0);
    check("rst_nodata", nodata, 0);
    check("rst_phwrite", pw, 0);
    check("rst_phenable", {pe, phdata}, 0);

    prof[0] = a_prof;
    run(4'b0001, 0, 0);
    check("s1_best_I", best_phase[2:0], 3);

    prof[1] = t_prof;
    run(4'b0010, 0, 0);
    check("s2_best_II", best_phase[5:3], 0);

    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 4; c++) begin
        bit z = $urandom_range(0, 4) == 0;
        for (int p = 0; p < 8; p++) prof[c][p] = z ? 8'd0 : 8'($urandom_range(0, 255));
      end
      prof[2][$urandom_range(0, 7)] = 8'd1;
      run(4'($urandom_range(1, 15)), k[0], 0);
    end

    prof[0] = a_prof; prof[1] = a_prof; prof[3] = a_prof;
    for (int p = 0; p < 8; p++) prof[2][p] = 0;
    run(4'b1111, 0, 0);
    check("s3_nodata", nodata, 4'b0100);

    run(4'b0000, 0, 0);

    for (int c = 0; c < 4; c++) for (int p = 0; p < 8; p++) prof[c][p] = 8'($urandom_range(0, 255));
    @(negedge clk);
    ch_mask = 4'hf;
    start = 1;
    nd_m = 0;
    @(negedge clk);
    start = 0;
    got = 0;
    for (int n = 0; n < 100 && !got; n++) begin
      if (pw != 0 && pe != 0 && phdata == 3'd4) got = 1;
      else @(negedge clk);
    end
    check("abort_reach_p4", got, 1);
    repeat (2) @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("abort_busy", busy, 0);
    check("abort_phenable", pe, 0);
    bad = 0;
    repeat (10) @(negedge clk) if (done || busy || pw != 0) bad = 1;
    check("abort_quiet", bad, 0);
    check("abort_best", best_phase, bp_m);
    check("abort_nodata", nodata, nd_m);
    run(4'hf, 0, 0);

    run(4'hf, 0, 58);
    bad = 0;
    repeat (10) @(negedge clk) if (busy || pw != 0 || pe != 0) bad = 1;
    check("post_rst_quiet", bad, 0);
    run(4'b1011, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/deser400_phcal.md
Name: deser400_phcal

Overview:
- Automatic phase-calibration sequencer for the four deser400 channels (I..IV).
- Sweeps the shared phase-select write port through phases 0..7 and lets each phase detector settle before sampling its 8-bit xorsum.
- Picks, per channel, the phase with the lowest circular 3-tap xorsum window, then writes that phase back one channel at a time.
- Sits between the deser400 control register block (which issues start/abort/ch_mask and reads results) and the per-channel phase detectors.

Parameters:
- SETTLE_CYCLES, 1024: clk cycles each phase is held before xorsum is sampled (must be >= 1).
- SETTLE_W, 11: width of the settle counter (must satisfy 2^SETTLE_W > SETTLE_CYCLES).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin calibration
- abort  in  1  one-cycle request to stop and return to idle
- ch_mask  in  4  channels to calibrate, bit0=I .. bit3=IV
- xorsum_I, xorsum_II, xorsum_III, xorsum_IV  in  8 each  phase detector xorsum
- phwrite_I, phwrite_II, phwrite_III, phwrite_IV  out  1 each  phase write strobe
- phdata  out  3  phase value accompanying phwrite
- phenable_I, phenable_II, phenable_III, phenable_IV  out  1 each  phase detector enable
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse at completion
- nodata  out  4  per channel: all 8 samples were 0, so no phase was applied
- best_phase  out  12  {IV,III,II,I} phase chosen, 3 bits each

Behaviour:
- Reset: all outputs 0, state IDLE. Score RAM contents are don't-care after reset.
- Mask latch: ch_mask is latched on an accepted start and used for the whole run.
- States: IDLE, SET, SETTLE, SAMPLE, EVAL, APPLY, DONE.
- IDLE:
  - start=1 with latched mask nonzero -> SET, with p=0. Clears nodata.
  - start=1 with mask=0 -> DONE directly.
- SET (1 cycle):
  - phdata=p; phwrite_x=1 for each masked channel.
  - Next state SETTLE, settle counter cleared.
- SETTLE (exactly SETTLE_CYCLES cycles) -> SAMPLE.
- SAMPLE (1 cycle):
  - Store xorsum_x into score[x][p].
  - If p==7 -> EVAL with e=0; else p<=p+1 and -> SET.
- phenable_x:
  - Equals mask bit x in SET, SETTLE and SAMPLE.
  - 0 in all other states.
- EVAL (8 cycles, e=0..7, all channels in parallel):
  - win = score[e-1 mod 8] + score[e] + score[(e+1) mod 8], 10-bit unsigned, no overflow possible.
  - Strict less-than compare against the running minimum, so on a tie the lowest e wins.
  - The e=0 result initializes the running minimum.
  - Per channel, an OR of all 8 samples is tracked; a masked channel with OR==0 sets nodata_x.
- APPLY (4 cycles, channels I..IV in order):
  - A channel that is masked and has nodata_x=0: phdata=best, its phwrite=1, and best_phase field updated.
  - Otherwise the slot idles: no write, best_phase field unchanged.
- DONE (1 cycle): done=1, then -> IDLE.
- Latency, start to done pulse: 8*(SETTLE_CYCLES+2) + 8 + 4 + 1 cycles after the start cycle. With mask=0: 1 cycle.
- Strobes: phwrite is never asserted for more than one cycle per SET/APPLY slot. phdata is 0 whenever no phwrite is active.
- start while busy: ignored.
- abort:
  - In any non-IDLE state -> IDLE on the next edge.
  - No done pulse; phenable drops immediately (registered).
  - best_phase and nodata keep their prior values.
  - abort and start in the same IDLE cycle: abort wins, start is ignored.
- reset_n deasserting mid-run: all state cleared asynchronously; no write is issued after reset_n goes low.

Decomposition:
- Shared package deser400_pkg holds:
  - state enum
  - NUM_CH=4, NUM_PH=8
  - score width 8, window width 10
- Sub-module deser400_phcal_score: a per-channel 8x8 score store plus the 3-tap window min-search. It has a write port, an eval index input, and outputs best[2:0] and anydata. It is instantiated 4 times.

Test Plan (all scenarios use SETTLE_CYCLES=4):
- Single channel:
  - Stimulus: mask=0001; xorsum_I returns {p0..p7}={90,80,10,0,5,70,90,95} per swept phase.
  - Required: windows min at p=3 (15); APPLY issues phwrite_I with phdata=3; best_phase[2:0]=3; done exactly 61 cycles after start.
- Tie and wrap-around:
  - Stimulus: mask=0010; xorsum_II={0,50,50,50,50,50,50,0}.
  - Required: window minimum is 50, shared by e=0 and e=7; best=0; phwrite_II with phdata=0.
- No data:
  - Stimulus: mask=1111; xorsum_III is always 0; the other channels follow the first scenario's profile.
  - Required: nodata=0100; exactly 3 APPLY writes; best_phase[8:6] unchanged.
- Empty mask:
  - Stimulus: start with mask=0.
  - Required: done on the next cycle; no phwrite and no phenable ever asserted.
- Abort:
  - Stimulus: abort during the SETTLE of phase 4.
  - Required: busy=0 next cycle; all phenable=0; no done; best_phase retains its old value. A following start runs a full sweep from p=0.
- Async reset and ignored start:
  - Stimulus: pull reset_n low during APPLY.
  - Required: all outputs 0 immediately. A start pulsed while busy has no effect on the phase sequence.
